// File: rtl/fma_pp_issue_sched_if.sv
// Handshake bundle between operand requesters / result consumer and the
// FMA pipe issue scheduler.
interface fma_pp_issue_sched_if #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned CNT_W      = 3
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [TAG_W-1:0]      issue_sel;
  logic                  issue_valid;
  logic [PIPE_DEPTH-1:0] stage_en;
  logic                  out_valid;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_ready;
  logic                  flush;
  logic                  drain_req;
  logic                  drain_done;
  logic [CNT_W-1:0]      inflight;
  logic                  busy;

  modport master (
    output req_valid, out_ready, flush, drain_req,
    input  req_ready, issue_sel, issue_valid, stage_en, out_valid, out_tag,
           drain_done, inflight, busy
  );

  modport slave (
    input  req_valid, out_ready, flush, drain_req,
    output req_ready, issue_sel, issue_valid, stage_en, out_valid, out_tag,
           drain_done, inflight, busy
  );
endinterface

// File: rtl/fma_pp_issue_sched.sv
// Round-robin issue scheduler and stage sequencer for a shared FMA mantissa
// pipe: per-stage valid/tag tracking, whole-pipe stall, flush and drain.
module fma_pp_issue_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fma_pp_issue_sched_if.slave   bus
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [PIPE_DEPTH-1:0] v_q, v_d;
  logic [TAG_W-1:0]      tag_q [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_d [PIPE_DEPTH];
  logic [TAG_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic                  drained_q, drained_d;

  logic                  stall;
  logic                  eligible;
  logic                  found;
  logic                  drain_done;
  logic [NREQ-1:0]       req_ready;
  logic [TAG_W-1:0]      gnt_idx;
  logic [TAG_W-1:0]      idx;

  // rst_n gates the combinational outputs so they read zero during reset.
  always_comb begin
    stall     = v_q[PIPE_DEPTH-1] & ~bus.out_ready;
    eligible  = rst_n & (state_q == RUN) & ~bus.drain_req & ~stall & ~bus.flush;
    req_ready = '0;
    gnt_idx   = '0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = TAG_W'((32'(ptr_q) + i) % NREQ);
      if (eligible && !found && bus.req_valid[idx]) begin
        found          = 1'b1;
        gnt_idx        = idx;
        req_ready[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    v_d   = v_q;
    tag_d = tag_q;
    if (bus.flush) begin
      v_d = '0;
    end else if (!stall) begin
      v_d = {v_q[PIPE_DEPTH-2:0], found};
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        tag_d[k] = tag_q[k-1];
      end
      tag_d[0] = gnt_idx;
    end

    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    inflight_d = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      inflight_d = inflight_d + CNT_W'(v_d[k]);
    end

    // An empty pipe in DRAIN cannot shift (no grants), so inflight==0 suffices.
    // drained_q suppresses repeat pulses while drain_req stays high.
    drain_done = (state_q == DRAIN) && (inflight_q == '0) && !drained_q;
    drained_d  = bus.drain_req & (drained_q | drain_done);

    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.drain_req) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      v_q        <= '0;
      ptr_q      <= '0;
      inflight_q <= '0;
      drained_q  <= 1'b0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      drained_q  <= drained_d;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.issue_valid = found;
  assign bus.issue_sel   = gnt_idx;
  assign bus.stage_en    = {PIPE_DEPTH{rst_n & ~stall & ~bus.flush}};
  assign bus.out_valid   = v_q[PIPE_DEPTH-1];
  assign bus.out_tag     = tag_q[PIPE_DEPTH-1];
  assign bus.drain_done  = drain_done;
  assign bus.inflight    = inflight_q;
  assign bus.busy        = |inflight_q;

endmodule

// File: tb/tb_fma_pp_issue_sched.sv
// Directed bench for fma_pp_issue_sched: arbitration order, latency, stall,
// flush, drain and asynchronous reset, with hand-computed expectations.
module tb_fma_pp_issue_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fma_pp_issue_sched_if #(.NREQ(4), .PIPE_DEPTH(4), .TAG_W(2), .CNT_W(3)) bus ();

  fma_pp_issue_sched #(.NREQ(4), .PIPE_DEPTH(4), .TAG_W(2), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, let logic settle, then return.
  task automatic cyc(input logic [3:0] rv, input logic ordy, input logic fl, input logic dr);
    @(posedge clk);
    #1;
    bus.req_valid = rv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.drain_req = dr;
    #2;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    bus.drain_req = 1'b0;
    #3;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_issue_valid", 32'(bus.issue_valid), 0);
    chk("rst_stage_en", 32'(bus.stage_en), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_inflight", 32'(bus.inflight), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_drain_done", 32'(bus.drain_done), 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.req_valid = 4'h0;

    // All requesters valid: rotating grants, back-to-back results.
    for (int i = 0; i < 12; i++) begin
      cyc(4'hF, 1'b1, 1'b0, 1'b0);
      chk("rr_ready", 32'(bus.req_ready), 32'(1) << (i % 4));
      chk("rr_sel", 32'(bus.issue_sel), 32'(i % 4));
      if (i >= 4) begin
        chk("rr_out_valid", 32'(bus.out_valid), 1);
        chk("rr_out_tag", 32'(bus.out_tag), 32'((i - 4) % 4));
      end else begin
        chk("rr_out_idle", 32'(bus.out_valid), 0);
      end
    end
    for (int j = 0; j < 4; j++) begin
      cyc(4'h0, 1'b1, 1'b0, 1'b0);
      chk("rr_tail_valid", 32'(bus.out_valid), 1);
      chk("rr_tail_tag", 32'(bus.out_tag), 32'((8 + j) % 4));
      chk("rr_tail_inflight", 32'(bus.inflight), 32'(4 - j));
    end
    cyc(4'h0, 1'b1, 1'b0, 1'b0);
    chk("rr_empty_valid", 32'(bus.out_valid), 0);
    chk("rr_empty_busy", 32'(bus.busy), 0);

    // Single request on requester 2: latency of 4 cycles.
    cyc(4'b0100, 1'b1, 1'b0, 1'b0);
    chk("one_ready", 32'(bus.req_ready), 32'h4);
    chk("one_sel", 32'(bus.issue_sel), 2);
    chk("one_issue_valid", 32'(bus.issue_valid), 1);
    chk("one_stage_en", 32'(bus.stage_en), 32'hF);
    for (int k = 1; k <= 5; k++) begin
      cyc(4'h0, 1'b1, 1'b0, 1'b0);
      chk("one_out_valid", 32'(bus.out_valid), (k == 4) ? 1 : 0);
      chk("one_inflight", 32'(bus.inflight), (k < 5) ? 1 : 0);
      if (k == 4) chk("one_out_tag", 32'(bus.out_tag), 2);
    end

    // Four ops, then 3 stall cycles with the first result waiting.
    for (int i = 0; i < 4; i++) begin
      cyc(4'hF, 1'b1, 1'b0, 1'b0);
      chk("st_ready", 32'(bus.req_ready), 32'(1) << ((3 + i) % 4));
    end
    for (int s = 0; s < 3; s++) begin
      cyc(4'hF, 1'b0, 1'b0, 1'b0);
      chk("st_stage_en", 32'(bus.stage_en), 0);
      chk("st_ready_held", 32'(bus.req_ready), 0);
      chk("st_out_valid", 32'(bus.out_valid), 1);
      chk("st_out_tag", 32'(bus.out_tag), 3);
      chk("st_inflight", 32'(bus.inflight), 4);
    end
    for (int j = 0; j < 4; j++) begin
      cyc(4'h0, 1'b1, 1'b0, 1'b0);
      chk("st_drain_valid", 32'(bus.out_valid), 1);
      chk("st_drain_tag", 32'(bus.out_tag), 32'((3 + j) % 4));
    end
    cyc(4'h0, 1'b1, 1'b0, 1'b0);
    chk("st_empty", 32'(bus.inflight), 0);

    // Flush with 3 ops in flight; pointer (2) survives the flush.
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, 1'b1, 1'b0, 1'b0);
      chk("fl_ready", 32'(bus.req_ready), 32'(1) << ((3 + i) % 4));
    end
    cyc(4'hF, 1'b1, 1'b1, 1'b0);
    chk("fl_no_grant", 32'(bus.req_ready), 0);
    chk("fl_stage_en", 32'(bus.stage_en), 0);
    chk("fl_inflight_before", 32'(bus.inflight), 3);
    cyc(4'hF, 1'b1, 1'b0, 1'b0);
    chk("fl_out_valid", 32'(bus.out_valid), 0);
    chk("fl_inflight_after", 32'(bus.inflight), 0);
    chk("fl_ptr_kept", 32'(bus.req_ready), 32'h4);
    for (int k = 1; k <= 4; k++) begin
      cyc(4'h0, 1'b1, 1'b0, 1'b0);
      chk("fl_post_valid", 32'(bus.out_valid), (k == 4) ? 1 : 0);
      if (k == 4) chk("fl_post_tag", 32'(bus.out_tag), 2);
    end
    cyc(4'h0, 1'b1, 1'b0, 1'b0);

    // Drain with 2 ops in flight and requests pending.
    cyc(4'hF, 1'b1, 1'b0, 1'b0);
    chk("dr_g0", 32'(bus.req_ready), 32'h8);
    cyc(4'hF, 1'b1, 1'b0, 1'b0);
    chk("dr_g1", 32'(bus.req_ready), 32'h1);
    for (int c = 2; c <= 5; c++) begin
      cyc(4'hF, 1'b1, 1'b0, 1'b1);
      chk("dr_no_grant", 32'(bus.req_ready), 0);
      chk("dr_done_low", 32'(bus.drain_done), 0);
      chk("dr_inflight", 32'(bus.inflight), (c == 5) ? 1 : 2);
    end
    cyc(4'hF, 1'b1, 1'b0, 1'b1);
    chk("dr_done_pulse", 32'(bus.drain_done), 1);
    chk("dr_done_ready", 32'(bus.req_ready), 0);
    chk("dr_done_inflight", 32'(bus.inflight), 0);
    cyc(4'hF, 1'b1, 1'b0, 1'b1);
    chk("dr_hold_ready", 32'(bus.req_ready), 0);
    chk("dr_hold_done", 32'(bus.drain_done), 0);
    cyc(4'hF, 1'b1, 1'b0, 1'b0);
    chk("dr_drop_ready", 32'(bus.req_ready), 0);
    chk("dr_no_repeat", 32'(bus.drain_done), 0);
    cyc(4'hF, 1'b1, 1'b0, 1'b0);
    chk("dr_resume", 32'(bus.req_ready), 32'h2);
    for (int k = 1; k <= 5; k++) begin
      cyc(4'h0, 1'b1, 1'b0, 1'b0);
      if (k == 4) chk("dr_post_tag", 32'(bus.out_tag), 1);
    end

    // Drain requested with an already empty pipe.
    cyc(4'h0, 1'b1, 1'b0, 1'b1);
    chk("de_first", 32'(bus.drain_done), 0);
    cyc(4'h0, 1'b1, 1'b0, 1'b1);
    chk("de_pulse", 32'(bus.drain_done), 1);
    cyc(4'h0, 1'b1, 1'b0, 1'b0);
    chk("de_after", 32'(bus.drain_done), 0);

    // Asynchronous reset in the middle of a stalled stream.
    for (int i = 0; i < 4; i++) begin
      cyc(4'hF, 1'b1, 1'b0, 1'b0);
      chk("ar_ready", 32'(bus.req_ready), 32'(1) << ((2 + i) % 4));
    end
    cyc(4'hF, 1'b0, 1'b0, 1'b0);
    chk("ar_stalled_valid", 32'(bus.out_valid), 1);
    chk("ar_stalled_tag", 32'(bus.out_tag), 2);
    chk("ar_stalled_busy", 32'(bus.busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_req_ready", 32'(bus.req_ready), 0);
    chk("ar_issue_valid", 32'(bus.issue_valid), 0);
    chk("ar_issue_sel", 32'(bus.issue_sel), 0);
    chk("ar_stage_en", 32'(bus.stage_en), 0);
    chk("ar_out_valid", 32'(bus.out_valid), 0);
    chk("ar_out_tag", 32'(bus.out_tag), 0);
    chk("ar_inflight", 32'(bus.inflight), 0);
    chk("ar_busy", 32'(bus.busy), 0);
    chk("ar_drain_done", 32'(bus.drain_done), 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'hF;
    #2;
    chk("ar_first_grant", 32'(bus.req_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
